// File: rtl/chunk_sum.sv
// chunk_sum: groups upstream (in0, in1) beats into chunks of k and yields (sum, count) downstream.
// Defining CHUNK_SUM_OVF_EN adds the _ovf output (signed overflow seen within the emitted chunk).
module chunk_sum #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                    _clock,
  input  logic                    _reset,
  input  logic                    _start,
  input  logic [CNT_W-1:0]        k,
  output logic                    _up_start,
  output logic                    _up_ready,
  input  logic                    _up_valid,
  input  logic                    _up_done,
  input  logic signed [WIDTH-1:0] _in0,
  input  logic signed [WIDTH-1:0] _in1,
  input  logic                    _ready,
  output logic                    _valid,
  output logic                    _done,
  output logic signed [WIDTH-1:0] _out0,
  output logic [CNT_W-1:0]        _out1
`ifdef CHUNK_SUM_OVF_EN
  ,
  output logic                    _ovf
`endif
);

  // state | meaning
  // IDLE  | waiting for _start
  // ACCUM | accepting upstream beats
  // EMIT  | full chunk pending on the output
  // FLUSH | final partial chunk pending on the output
  // FIN   | one-cycle _done
  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_EMIT, S_FLUSH, S_FIN} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        kq_q, kq_d, cnt_q, cnt_d, out1_q, out1_d, cnt_n;
  logic signed [WIDTH-1:0] acc_q, acc_d, out0_q, out0_d, sum_a, sum_b, acc_n;
  logic                    valid_q, valid_d, done_q, done_d, up_start_q, up_start_d;
  logic                    done_flag_q, done_flag_d, beat;
`ifdef CHUNK_SUM_OVF_EN
  logic                    ovf_acc_q, ovf_acc_d, ovf_q, ovf_d, ovf_n;
`endif

  assign beat  = (state_q == S_ACCUM) && _up_valid;
  assign sum_a = acc_q + _in0;
  assign sum_b = sum_a + _in1;
  assign acc_n = beat ? sum_b : acc_q;
  assign cnt_n = beat ? cnt_q + CNT_W'(1) : cnt_q;
`ifdef CHUNK_SUM_OVF_EN
  // Two chained adds per beat; either one may overflow.
  assign ovf_n = ovf_acc_q | (beat &
                 (((acc_q[WIDTH-1] == _in0[WIDTH-1]) && (sum_a[WIDTH-1] != acc_q[WIDTH-1])) |
                  ((sum_a[WIDTH-1] == _in1[WIDTH-1]) && (sum_b[WIDTH-1] != sum_a[WIDTH-1]))));
`endif

  always_comb begin
    state_d     = state_q;
    kq_d        = kq_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out0_d      = out0_q;
    out1_d      = out1_q;
    valid_d     = valid_q;
    done_flag_d = done_flag_q;
    done_d      = 1'b0;
    up_start_d  = 1'b0;
`ifdef CHUNK_SUM_OVF_EN
    ovf_acc_d   = ovf_acc_q;
    ovf_d       = ovf_q;
`endif
    if (_start) begin
      kq_d        = (k == '0) ? CNT_W'(1) : k;
      acc_d       = '0;
      cnt_d       = '0;
      valid_d     = 1'b0;
      done_flag_d = 1'b0;
      up_start_d  = 1'b1;
      state_d     = S_ACCUM;
`ifdef CHUNK_SUM_OVF_EN
      ovf_acc_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        S_ACCUM: begin
          acc_d = acc_n;
          cnt_d = cnt_n;
`ifdef CHUNK_SUM_OVF_EN
          ovf_acc_d = ovf_n;
`endif
          // The beat is folded in first; a full chunk with done pending goes through EMIT.
          if ((beat && cnt_n == kq_q) || (_up_done && cnt_n != '0)) begin
            out0_d      = acc_n;
            out1_d      = cnt_n;
            valid_d     = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            done_flag_d = _up_done;
            state_d     = (beat && cnt_n == kq_q) ? S_EMIT : S_FLUSH;
`ifdef CHUNK_SUM_OVF_EN
            ovf_d     = ovf_n;
            ovf_acc_d = 1'b0;
`endif
          end else if (_up_done) begin
            state_d = S_FIN;
          end
        end
        S_EMIT: begin
          if (_up_done) done_flag_d = 1'b1;
          if (valid_q && _ready) begin
            valid_d     = 1'b0;
            done_flag_d = 1'b0;
            state_d     = (done_flag_q || _up_done) ? S_FIN : S_ACCUM;
          end
        end
        S_FLUSH: begin
          if (valid_q && _ready) begin
            valid_d     = 1'b0;
            done_flag_d = 1'b0;
            state_d     = S_FIN;
          end
        end
        S_FIN: begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        S_IDLE: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      state_q     <= S_IDLE;
      kq_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out0_q      <= '0;
      out1_q      <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      up_start_q  <= 1'b0;
      done_flag_q <= 1'b0;
`ifdef CHUNK_SUM_OVF_EN
      ovf_acc_q   <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      kq_q        <= kq_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out0_q      <= out0_d;
      out1_q      <= out1_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      up_start_q  <= up_start_d;
      done_flag_q <= done_flag_d;
`ifdef CHUNK_SUM_OVF_EN
      ovf_acc_q   <= ovf_acc_d;
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign _up_start = up_start_q;
  assign _up_ready = (state_q == S_ACCUM);
  assign _valid    = valid_q;
  assign _done     = done_q;
  assign _out0     = out0_q;
  assign _out1     = out1_q;
`ifdef CHUNK_SUM_OVF_EN
  assign _ovf      = ovf_q;
`endif

endmodule

// File: tb/tb_chunk_sum.sv
// Scoreboard bench for chunk_sum: a range-generator model feeds the upstream side,
// expected (sum, count) tuples are queued per scenario and checked by a separate monitor.
module tb_chunk_sum;
  localparam int WIDTH = 32;
  localparam int CNT_W = 16;

  typedef struct packed {
    logic [31:0] o0;
    logic [15:0] o1;
    logic        ov;
  } exp_t;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, ready = 1'b0;
  logic [CNT_W-1:0] k = '0;
  logic up_start, up_ready, valid, done;
  logic up_valid = 1'b0, up_done = 1'b0;
  logic signed [WIDTH-1:0] in0 = '0, in1 = '0, out0;
  logic [CNT_W-1:0] out1;
`ifdef CHUNK_SUM_OVF_EN
  logic ovf;
`endif

  exp_t exp_q[$];
  logic signed [WIDTH-1:0] g0[$], g1[$];
  int n_chk = 0, n_pass = 0, done_cnt = 0, done_cyc = 0, updone_cyc = 0, pops = 0, cyc = 0;

  chunk_sum #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    ._clock(clk), ._reset(rst), ._start(start), .k(k),
    ._up_start(up_start), ._up_ready(up_ready), ._up_valid(up_valid), ._up_done(up_done),
    ._in0(in0), ._in1(in1), ._ready(ready), ._valid(valid), ._done(done),
    ._out0(out0), ._out1(out1)
`ifdef CHUNK_SUM_OVF_EN
    , ._ovf(ovf)
`endif
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0d (0x%08h), required %0d (0x%08h)", nm, act, act, expv, expv);
  endtask

  task automatic chk1(input string nm, input logic act, input logic expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %b, required %b", nm, act, expv);
  endtask

  task automatic expect_out(input int o0, input int o1, input bit ov);
    exp_t e;
    e.o0 = o0;
    e.o1 = 16'(o1);
    e.ov = ov;
    exp_q.push_back(e);
  endtask

  task automatic load_range(input int n);
    g0.delete();
    g1.delete();
    for (int i = 0; i < n; i++) begin
      g0.push_back(i);
      g1.push_back(i);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_valid"}, valid, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
    chk1({tag, "_up_start"}, up_start, 1'b0);
    chk1({tag, "_up_ready"}, up_ready, 1'b0);
    chk({tag, "_out0"}, out0, 32'd0);
    chk({tag, "_out1"}, 32'(out1), 32'd0);
  endtask

  // Drives one run: start, upstream range generator, caller backpressure; optional reset after rst_at beats.
  task automatic run(input int kv, input int stall, input int rst_at);
    int idx = 0, stall_left = 0, budget = 0;
    int done0 = done_cnt, pops0 = pops, nexp = exp_q.size();
    bit armed = (stall > 0), rdy_s = 1'b0, sent = 1'b0;
    @(negedge clk);
    start = 1'b1;
    k = CNT_W'(kv);
    ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!up_start && budget < 8) begin
      @(negedge clk);
      budget++;
    end
    chk1("up_start_seen", up_start, 1'b1);
    budget = 0;
    while (done_cnt == done0 && budget < 400) begin
      if (up_valid && rdy_s) idx++;
      if (rst_at > 0 && idx == rst_at) break;
      up_done = 1'b0;
      if (idx < g0.size()) begin
        up_valid = 1'b1;
        in0 = g0[idx];
        in1 = g1[idx];
      end else begin
        up_valid = 1'b0;
        if (!sent) begin
          up_done = 1'b1;
          sent = 1'b1;
          updone_cyc = cyc;
        end
      end
      rdy_s = up_ready;
      if (armed && valid) begin
        armed = 1'b0;
        stall_left = stall;
      end
      if (stall_left > 0) begin
        ready = 1'b0;
        stall_left--;
      end else ready = 1'b1;
      @(negedge clk);
      budget++;
    end
    if (rst_at > 0) begin
      chk("reset_point_reached", idx, rst_at);
      #2 rst = 1'b1;
      #1 chk_all_zero("midrun_reset");
      up_valid = 1'b0;
      up_done = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("no_done_after_reset", done_cnt - done0, 0);
      exp_q.delete();
    end else begin
      chk1("run_within_budget", budget < 400, 1'b1);
      up_valid = 1'b0;
      up_done = 1'b0;
      ready = 1'b1;
      repeat (4) @(negedge clk);
      chk("done_pulses", done_cnt - done0, 1);
      chk("outputs_taken", pops - pops0, nexp);
      chk("queue_empty", exp_q.size(), 0);
    end
  endtask

  // Monitor: compares the presented tuple with the queue head every valid cycle, pops on handshake.
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (!rst) begin
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk1("valid_low_at_done", valid, 1'b0);
      end
      if (valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_valid: got out0=%0d out1=%0d, required no output", out0, out1);
        end else begin
          e = exp_q[0];
          chk("out0", out0, e.o0);
          chk("out1", 32'(out1), 32'(e.o1));
          chk1("up_ready_backpressure", up_ready, 1'b0);
`ifdef CHUNK_SUM_OVF_EN
          chk1("ovf", ovf, e.ov);
`endif
          if (ready) begin
            e = exp_q.pop_front();
            pops++;
          end
        end
      end
    end
  end

  initial begin
    #2 rst = 1'b1;
    #1 chk_all_zero("reset");
    @(negedge clk);
    start = 1'b1;
    k = 16'd4;
    @(negedge clk);
    #1 chk1("reset_over_start_up_start", up_start, 1'b0);
    chk1("reset_over_start_up_ready", up_ready, 1'b0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    load_range(10);
    expect_out(12, 4, 0); expect_out(44, 4, 0); expect_out(34, 2, 0);
    run(4, 0, 0);

    load_range(10);
    expect_out(20, 5, 0); expect_out(70, 5, 0);
    run(5, 0, 0);

    load_range(0);
    run(3, 0, 0);
    chk("done_gap_after_up_done", done_cyc - updone_cyc, 2);

    load_range(10);
    expect_out(12, 4, 0); expect_out(44, 4, 0); expect_out(34, 2, 0);
    run(4, 6, 0);

    g0 = '{32'sd5, 32'sd5, 32'sd5, 32'sh7FFF_FFFF};
    g1 = '{-32'sd2, -32'sd2, -32'sd2, 32'sd1};
    expect_out(3, 1, 0); expect_out(3, 1, 0); expect_out(3, 1, 0);
    expect_out(32'h8000_0000, 1, 1);
    run(0, 0, 0);

    load_range(10);
    expect_out(12, 4, 0);
    run(4, 0, 6);

    load_range(10);
    expect_out(12, 4, 0); expect_out(44, 4, 0); expect_out(34, 2, 0);
    run(4, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/chunk_sum.md
Name: chunk_sum

Overview:
- Downstream consumer of a two-output generator module, such as a tuple-yielding range generator.
- Implements the Python generator `for a, b in gen: acc += a + b; cnt += 1; if cnt == k: yield acc, cnt; acc = cnt = 0` followed by `if cnt: yield acc, cnt`.
- Sits between a generator instance and its caller. Upstream side: that generator's ready/valid/done outputs. Downstream side: the same _start/_ready/_valid/_done protocol.

Parameters:
- WIDTH, 32, width of input operands, accumulator and _out0 (signed).
- CNT_W, 16, width of k and _out1 (unsigned).

Ports:
- _clock  input  1  clock; all state updates on the rising edge.
- _reset  input  1  asynchronous, active-high reset.
- _start  input  1  captures k and starts a new run; pulses _up_start.
- k  input  CNT_W  chunk size, sampled only when _start is high.
- _up_start  output  1  one-cycle start pulse to the upstream generator.
- _up_ready  output  1  ready to the upstream generator.
- _up_valid  input  1  upstream beat valid.
- _up_done  input  1  upstream one-cycle done pulse.
- _in0  input  WIDTH  upstream tuple element 0 (signed).
- _in1  input  WIDTH  upstream tuple element 1 (signed).
- _ready  input  1  caller ready for output.
- _valid  output  1  _out0/_out1 valid.
- _done  output  1  one-cycle pulse: run finished.
- _out0  output  WIDTH  chunk sum (signed).
- _out1  output  CNT_W  number of beats in the chunk.

Behaviour:
- Reset:
  - Asynchronous assert forces IDLE; clears acc and cnt.
  - All outputs go to 0: _up_start, _up_ready, _valid, _done, _out0, _out1.
  - Reset wins over _start while asserted.
  - Reset mid-run discards any pending output; no _done is emitted.
- States:
  - IDLE: waiting for _start.
  - ACCUM: accepting upstream beats.
  - EMIT: full chunk pending on the output.
  - FLUSH: final partial chunk pending on the output.
  - FIN: emit _done.
- _start (any state):
  - Latch kq = (k == 0 ? 1 : k).
  - Clear acc and cnt; drop _valid.
  - _up_start = 1 for exactly one cycle.
  - Go to ACCUM. A restart mid-run abandons the current chunk.
- ACCUM:
  - _up_ready = 1.
  - A beat is accepted when _up_ready && _up_valid. Then acc += _in0 + _in1 and cnt += 1.
  - Addition wraps modulo 2^WIDTH; no saturation.
  - If the new cnt == kq: register _out0 = new acc and _out1 = kq, set _valid = 1, clear acc and cnt, and go to EMIT.
  - Latency: _valid rises on the cycle after the k-th beat is accepted.
- Upstream done:
  - If _up_valid and _up_done arrive in the same cycle, the beat is accepted first, then done is processed.
  - Done with cnt > 0 after the beat: emit the partial chunk (_out1 = cnt) and go to FLUSH.
  - Done with cnt == 0: go to FIN.
  - If done arrives while in EMIT, it is remembered in a flag and acted on after the EMIT handshake.
- EMIT / FLUSH:
  - _up_ready = 0 (backpressure upstream).
  - _out0/_out1/_valid hold stable while _valid && !_ready.
  - On _valid && _ready: drop _valid next cycle.
  - From EMIT: go to ACCUM, or to FIN if the done flag is set.
  - From FLUSH: go to FIN.
- FIN:
  - _done = 1 for one cycle with _valid = 0, then go to IDLE.
  - Upstream done with zero accepted beats: _done appears 2 cycles after the _up_done pulse.
- IDLE: _up_ready = 0; upstream inputs are ignored.

Optional Feature:
- Macro: CHUNK_SUM_OVF_EN.
- Defined:
  - Adds output _ovf (1 bit), registered alongside _valid.
  - _ovf is set if any signed addition within the emitted chunk overflowed WIDTH.
  - It is cleared when the chunk is cleared and on reset.
- Undefined: the port and logic are absent; wrap-around is silent.

Test Plan:
- Upstream range n=10, yields (i,i); k=4, _ready held 1 -> outputs (12,4), (44,4), (34,2), then one-cycle _done. Exactly 3 _valid beats.
- Same stream with k=5 -> (20,5), (70,5), then _done. No partial chunk is emitted.
- Upstream n=0 (immediate _up_done, no beats), k=3 -> no _valid; _done pulses exactly 2 cycles after the _up_done pulse.
- k=4, _ready held 0 for 6 cycles after the first _valid -> _out0=12 and _out1=4 stay stable and _up_ready stays 0. After _ready rises, the stream completes identically to the first scenario.
- k=0, 3 beats of (5,-2) -> outputs (3,1) three times. With WIDTH=32, the beat (0x7FFFFFFF, 1) -> _out0 = 0x80000000 and, when CHUNK_SUM_OVF_EN is defined, _ovf = 1.
- Assert _reset mid-chunk (cnt=2) -> all outputs are 0 immediately, without waiting for a clock edge, and no _done is emitted. A subsequent _start with k=4 reproduces the first scenario.
